// File: rtl/cyclic_lamp_checker.sv
// Sequence monitor for the cyclic lamp bus: locks onto 100 -> 010 -> 001 with a fixed dwell,
// pulses on violations while locked and keeps saturating error / wrapping cycle counters.
module cyclic_lamp_checker #(
    parameter int DWELL  = 1,
    parameter int LOCK_N = 3,
    parameter int ERR_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       light,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       cur_phase
);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [2:0] prev;
    logic [7:0] dwell;
    logic [3:0] good;

    logic       valid;
    logic [1:0] phase;
    logic [2:0] nxt;
    logic       hold, legal, viol, lock_now, cyc_inc, err_inc;

    always_comb begin
        valid = 1'b1;
        phase = 2'd3;
        case (light)
            3'b100:  phase = 2'd0;
            3'b010:  phase = 2'd1;
            3'b001:  phase = 2'd2;
            default: valid = 1'b0;
        endcase
    end

    // One-hot rotate right gives the successor lamp code.
    assign nxt      = {prev[0], prev[2:1]};
    assign hold     = (state != HUNT) && (light == prev) && (dwell < 8'(DWELL));
    assign legal    = (state != HUNT) && (light == nxt) && (dwell == 8'(DWELL));
    assign viol     = (state != HUNT) && !hold && !legal;
    assign lock_now = (state == SYNC) && legal && (({1'b0, good} + 5'd1) == 5'(LOCK_N));
    assign cyc_inc  = (state == LOCKED) && legal && (light == 3'b100);
    assign err_inc  = (state == LOCKED) && viol;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= HUNT;
            prev        <= 3'b000;
            dwell       <= 8'd1;
            good        <= 4'd0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
            cycle_count <= '0;
            cur_phase   <= 2'd3;
        end else begin
            err_pulse <= err_inc;
            if (clr) begin
                err_count   <= '0;
                cycle_count <= '0;
            end else begin
                if (err_inc && (err_count != '1)) err_count <= err_count + ERR_ONE;
                if (cyc_inc) cycle_count <= cycle_count + CNT_ONE;
            end

            if (state == HUNT || viol) begin
                // Re-seed: a valid code restarts lock acquisition, anything else hunts.
                locked <= 1'b0;
                if (valid) begin
                    prev      <= light;
                    dwell     <= 8'd1;
                    good      <= 4'd0;
                    state     <= SYNC;
                    cur_phase <= phase;
                end else begin
                    state     <= HUNT;
                    cur_phase <= 2'd3;
                end
            end else if (hold) begin
                dwell <= dwell + 8'd1;
            end else begin
                prev      <= light;
                dwell     <= 8'd1;
                cur_phase <= phase;
                if (state == SYNC) begin
                    good <= good + 4'd1;
                    if (lock_now) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cyclic_lamp_checker.sv
// Bench for cyclic_lamp_checker: three parameterisations share the stimulus and are each
// compared against a phase-index reference model, plus directed checks per scenario.
module tb_cyclic_lamp_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] light = 3'b100;
    logic       clr = 1'b0;

    logic lk_a, ep_a, lk_b, ep_b, lk_c, ep_c;
    logic [1:0]  ph_a, ph_b, ph_c;
    logic [7:0]  ec_a, ec_b;
    logic [1:0]  ec_c;
    logic [15:0] cc_a, cc_b;
    logic [3:0]  cc_c;

    always #5 clk = ~clk;

    cyclic_lamp_checker #(.DWELL(1), .LOCK_N(3), .ERR_W(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .light(light), .clr(clr), .locked(lk_a), .err_pulse(ep_a),
        .err_count(ec_a), .cycle_count(cc_a), .cur_phase(ph_a));
    cyclic_lamp_checker #(.DWELL(3), .LOCK_N(1), .ERR_W(8), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .light(light), .clr(clr), .locked(lk_b), .err_pulse(ep_b),
        .err_count(ec_b), .cycle_count(cc_b), .cur_phase(ph_b));
    cyclic_lamp_checker #(.DWELL(1), .LOCK_N(3), .ERR_W(2), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .light(light), .clr(clr), .locked(lk_c), .err_pulse(ep_c),
        .err_count(ec_c), .cycle_count(cc_c), .cur_phase(ph_c));

    logic [27:0] obs [3];
    assign obs[0] = {lk_a, ep_a, ph_a, ec_a, cc_a};
    assign obs[1] = {lk_b, ep_b, ph_b, ec_b, cc_b};
    assign obs[2] = {lk_c, ep_c, ph_c, 6'b0, ec_c, 12'b0, cc_c};

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: st 0=HUNT 1=SYNC 2=LOCKED, ph is the phase index of the accepted code.
    int P_D [3] = '{1, 3, 1};
    int P_L [3] = '{3, 1, 3};
    int P_EW[3] = '{8, 8, 2};
    int P_CW[3] = '{16, 16, 4};
    int m_st[3], m_ph[3], m_dw[3], m_good[3], m_ec[3], m_cc[3];
    bit m_ep[3];

    function automatic int phase_of(logic [2:0] c);
        case (c)
            3'b100:  return 0;
            3'b010:  return 1;
            3'b001:  return 2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [2:0] code_of(int p);
        case (p)
            0:       return 3'b100;
            1:       return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [27:0] exp_v(int i);
        logic [1:0] ph;
        ph = (m_st[i] == 0) ? 2'd3 : 2'(m_ph[i]);
        return {(m_st[i] == 2), m_ep[i], ph, 8'(m_ec[i]), 16'(m_cc[i])};
    endfunction

    task automatic model_step(input logic [2:0] s, input logic c, input logic r);
        for (int i = 0; i < 3; i++) begin
            int p;
            bit rs, inc_e, inc_c;
            p = phase_of(s);
            rs = 0; inc_e = 0; inc_c = 0;
            m_ep[i] = 0;
            if (!r) begin
                m_st[i] = 0; m_ph[i] = -1; m_dw[i] = 1; m_good[i] = 0; m_ec[i] = 0; m_cc[i] = 0;
            end else begin
                if (m_st[i] == 0) rs = 1;
                else if (p == m_ph[i] && m_dw[i] < P_D[i]) m_dw[i]++;
                else if (p >= 0 && p == (m_ph[i] + 1) % 3 && m_dw[i] == P_D[i]) begin
                    m_ph[i] = p;
                    m_dw[i] = 1;
                    if (m_st[i] == 1) begin
                        m_good[i]++;
                        if (m_good[i] == P_L[i]) m_st[i] = 2;
                    end else if (p == 0) inc_c = 1;
                end else begin
                    if (m_st[i] == 2) begin m_ep[i] = 1; inc_e = 1; end
                    rs = 1;
                end
                if (rs) begin
                    if (p >= 0) begin m_ph[i] = p; m_dw[i] = 1; m_good[i] = 0; m_st[i] = 1; end
                    else m_st[i] = 0;
                end
                if (c) begin
                    m_ec[i] = 0; m_cc[i] = 0;
                end else begin
                    if (inc_e && m_ec[i] < (1 << P_EW[i]) - 1) m_ec[i]++;
                    if (inc_c) m_cc[i] = (m_cc[i] + 1) % (1 << P_CW[i]);
                end
            end
        end
    endtask

    task automatic drive(input logic [2:0] s, input logic c, input logic r);
        light = s; clr = c; rst_n = r;
        @(posedge clk);
        model_step(s, c, r);
        #1;
    endtask

    task automatic do_reset();
        drive(3'b100, 1'b0, 1'b0);
        drive(3'b100, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) drive(3'b100, 1'b1, 1'b0);
        n_chk++;
        if ({lk_a, ep_a, ph_a, ec_a, cc_a} !== {1'b0, 1'b0, 2'd3, 8'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", {lk_a, ep_a, ph_a, ec_a, cc_a}, 28'h3000000);
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs[i] !== exp_v(i)) begin
                n_fail++;
                $display("FAIL reset_model[%0d]: got %h want %h", i, obs[i], exp_v(i));
            end
        end
        drive(3'b100, 1'b0, 1'b1);
        n_chk++;
        if (ph_a !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_first_phase: got %0d want 0", ph_a);
        end
    endtask

    task automatic test_clean_run();
        logic [2:0] seq [7] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b100};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive(seq[k], 1'b0, 1'b1);
            n_chk++;
            if (lk_a !== (k >= 3) || ep_a !== 1'b0 || ec_a !== 8'd0) begin
                n_fail++;
                $display("FAIL clean_run[%0d]: locked=%b pulse=%b err=%0d want locked=%b pulse=0 err=0",
                         k, lk_a, ep_a, ec_a, (k >= 3));
            end
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (obs[i] !== exp_v(i)) begin
                    n_fail++;
                    $display("FAIL clean_model[%0d]: got %h want %h", i, obs[i], exp_v(i));
                end
            end
        end
        n_chk++;
        if (cc_a !== 16'd1) begin
            n_fail++;
            $display("FAIL clean_cycles: got %0d want 1", cc_a);
        end
    endtask

    task automatic test_skip();
        drive(3'b001, 1'b0, 1'b1);
        n_chk++;
        if ({ep_a, ec_a, lk_a, ph_a} !== {1'b1, 8'd1, 1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL skip_violation: pulse=%b err=%0d locked=%b phase=%0d want 1,1,0,2",
                     ep_a, ec_a, lk_a, ph_a);
        end
        drive(3'b100, 1'b0, 1'b1);
        n_chk++;
        if (ep_a !== 1'b0) begin
            n_fail++;
            $display("FAIL skip_pulse_width: got %b want 0", ep_a);
        end
        drive(3'b010, 1'b0, 1'b1);
        drive(3'b001, 1'b0, 1'b1);
        n_chk++;
        if (lk_a !== 1'b1 || ec_a !== 8'd1) begin
            n_fail++;
            $display("FAIL skip_relock: locked=%b err=%0d want 1,1", lk_a, ec_a);
        end
    endtask

    task automatic test_invalid();
        do_reset();
        drive(3'b100, 1'b0, 1'b1);
        drive(3'b010, 1'b0, 1'b1);
        drive(3'b001, 1'b0, 1'b1);
        drive(3'b100, 1'b0, 1'b1);
        drive(3'b000, 1'b0, 1'b1);
        n_chk++;
        if ({ep_a, ec_a, lk_a, ph_a} !== {1'b1, 8'd1, 1'b0, 2'd3}) begin
            n_fail++;
            $display("FAIL invalid_violation: pulse=%b err=%0d locked=%b phase=%0d want 1,1,0,3",
                     ep_a, ec_a, lk_a, ph_a);
        end
        drive(3'b011, 1'b0, 1'b1);
        n_chk++;
        if ({ep_a, ec_a, lk_a, ph_a} !== {1'b0, 8'd1, 1'b0, 2'd3}) begin
            n_fail++;
            $display("FAIL invalid_hunt: pulse=%b err=%0d locked=%b phase=%0d want 0,1,0,3",
                     ep_a, ec_a, lk_a, ph_a);
        end
    endtask

    task automatic test_dwell();
        do_reset();
        for (int k = 0; k < 3; k++) drive(3'b001, 1'b0, 1'b1);
        drive(3'b100, 1'b0, 1'b1);
        n_chk++;
        if (lk_b !== 1'b1) begin
            n_fail++;
            $display("FAIL dwell_lock: got %b want 1", lk_b);
        end
        drive(3'b100, 1'b0, 1'b1);
        drive(3'b100, 1'b0, 1'b1);
        n_chk++;
        if (ep_b !== 1'b0 || lk_b !== 1'b1) begin
            n_fail++;
            $display("FAIL dwell_hold: pulse=%b locked=%b want 0,1", ep_b, lk_b);
        end
        drive(3'b100, 1'b0, 1'b1);
        n_chk++;
        if (ep_b !== 1'b1 || ec_b !== 8'd1 || lk_b !== 1'b0) begin
            n_fail++;
            $display("FAIL dwell_overstay: pulse=%b err=%0d locked=%b want 1,1,0", ep_b, ec_b, lk_b);
        end
        do_reset();
        for (int k = 0; k < 3; k++) drive(3'b001, 1'b0, 1'b1);
        drive(3'b100, 1'b0, 1'b1);
        drive(3'b100, 1'b0, 1'b1);
        drive(3'b010, 1'b0, 1'b1);
        n_chk++;
        if (ep_b !== 1'b1 || ec_b !== 8'd1 || ph_b !== 2'd1) begin
            n_fail++;
            $display("FAIL dwell_early: pulse=%b err=%0d phase=%0d want 1,1,1", ep_b, ec_b, ph_b);
        end
    endtask

    task automatic test_saturate();
        logic [2:0] v;
        do_reset();
        drive(3'b100, 1'b0, 1'b1);
        drive(3'b010, 1'b0, 1'b1);
        drive(3'b001, 1'b0, 1'b1);
        drive(3'b100, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            v = code_of((m_ph[2] + 2) % 3);
            drive(v, 1'b0, 1'b1);
            n_chk++;
            if (ep_c !== 1'b1 || ec_c !== 2'((k > 3) ? 3 : k)) begin
                n_fail++;
                $display("FAIL sat_count[%0d]: pulse=%b err=%0d want 1,%0d", k, ep_c, ec_c, (k > 3) ? 3 : k);
            end
            for (int j = 0; j < 3; j++) drive(code_of((m_ph[2] + 1) % 3), 1'b0, 1'b1);
            n_chk++;
            if (lk_c !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_relock[%0d]: got %b want 1", k, lk_c);
            end
        end
        v = code_of((m_ph[2] + 2) % 3);
        drive(v, 1'b1, 1'b1);
        n_chk++;
        if (ep_c !== 1'b1 || ec_c !== 2'd0 || cc_c !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_clear: pulse=%b err=%0d cyc=%0d want 1,0,0", ep_c, ec_c, cc_c);
        end
    endtask

    task automatic test_random();
        int g = 0, h = 0, hold_len;
        logic [2:0] s;
        logic r, c;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            int pick;
            hold_len = (n < 700) ? 1 : 3;
            pick = $urandom_range(0, 59);
            r = 1'b1;
            if (pick == 0) s = 3'($urandom_range(0, 7));
            else if (pick == 1) begin s = code_of(g); r = 1'b0; end
            else begin
                s = code_of(g);
                h++;
                if (h >= hold_len) begin g = (g + 1) % 3; h = 0; end
            end
            c = ($urandom_range(0, 99) == 0);
            drive(s, c, r);
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (obs[i] !== exp_v(i)) begin
                    n_fail++;
                    $display("FAIL random[%0d] dut%0d: got %h want %h", n, i, obs[i], exp_v(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_skip();
        test_invalid();
        test_dwell();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
